// File: rtl/mimo_backsub_detector.sv
// N-stream MIMO back-substitution detector: loads z = Q^H*y, R and 1/R_ii, solves
// R*x = z through one complex MAC, then streams x and its QPSK/16-QAM Gray bits.
module mimo_backsub_slice #(
    parameter int W    = 28,
    parameter int FRAC = 8
) (
    input  logic signed [W-1:0] v,
    output logic [1:0]          bits
);
    logic signed [W-1:0] thr;

    always_comb begin
        thr = W'(2 << FRAC);
        // bits[1] is the sign decision, so QPSK reuses it directly
        if (v < -thr)     bits = 2'b00;
        else if (v[W-1])  bits = 2'b01;
        else if (v < thr) bits = 2'b11;
        else              bits = 2'b10;
    end
endmodule

module mimo_backsub_detector #(
    parameter int N    = 2,
    parameter int W    = 28,
    parameter int FRAC = 8,
    parameter int AW   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AW-1:0]       in_addr,
    input  logic signed [W-1:0] in_real,
    input  logic signed [W-1:0] in_imag,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_idx,
    output logic signed [W-1:0] out_x_real,
    output logic signed [W-1:0] out_x_imag,
    output logic [3:0]          out_sym
);
    localparam int NR = (N * (N - 1)) / 2;
    localparam int AC = W + 2;
    localparam int PW = 2 * W + 1;
    localparam int QW = AC + W;

    typedef enum logic [1:0] {S_LOAD, S_SOLVE, S_OUT} state_t;

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } cplx_t;

    function automatic int ridx(input int i, input int j);
        return i * (N - 1) - (i * (i - 1)) / 2 + (j - i - 1);
    endfunction

    function automatic logic [W-1:0] sat(input logic signed [QW-1:0] v);
        logic signed [QW-1:0] hi, lo;
        hi = {{(QW-W+1){1'b0}}, {(W-1){1'b1}}};
        lo = ~hi;
        if (v > hi)      return {1'b0, {(W-1){1'b1}}};
        else if (v < lo) return {1'b1, {(W-1){1'b0}}};
        else             return v[W-1:0];
    endfunction

    state_t                  state;
    logic [1:0]              row, step;
    logic                    mode_q;
    logic signed [AC-1:0]    acc_re, acc_im;
    cplx_t [N-1:0]           z, x;
    cplx_t [NR-1:0]          r;
    logic [N-1:0][W-1:0]     rinv;

    logic signed [AC-1:0]    a_re, a_im, acc_re_n, acc_im_n;
    logic signed [W-1:0]     rv;
    cplx_t                   rij, xj, xn, nxt, sl_src;
    logic signed [PW-1:0]    p_re, p_im;
    logic signed [QW-1:0]    q_re, q_im;
    logic                    last_step;
    logic [1:0][W-1:0]       sl_v;
    logic [1:0][1:0]         sl_b;
    logic [3:0]              sym_n;

    always_comb begin
        a_re = acc_re;
        a_im = acc_im;
        rv   = '0;
        rij  = '0;
        xj   = '0;
        nxt  = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(row) == i) begin
                rv = rinv[i];
                // first cycle of a row seeds the accumulator from z_i
                if (step == 2'd0) begin
                    a_re = AC'($signed(z[i].re));
                    a_im = AC'($signed(z[i].im));
                end
            end
            if (int'(row) + int'(step) + 1 == i) xj = x[i];
            if (int'(out_idx) + 1 == i) nxt = x[i];
        end
        for (int k = 0; k < NR; k++)
            if (k == ridx(int'(row), int'(row) + int'(step) + 1)) rij = r[k];

        last_step = (int'(step) == N - 1 - int'(row));

        p_re = PW'($signed(rij.re)) * PW'($signed(xj.re)) - PW'($signed(rij.im)) * PW'($signed(xj.im));
        p_im = PW'($signed(rij.re)) * PW'($signed(xj.im)) + PW'($signed(rij.im)) * PW'($signed(xj.re));
        acc_re_n = a_re - AC'($signed(W'(p_re >>> FRAC)));
        acc_im_n = a_im - AC'($signed(W'(p_im >>> FRAC)));

        q_re  = QW'(a_re) * QW'(rv);
        q_im  = QW'(a_im) * QW'(rv);
        xn.re = sat(q_re >>> FRAC);
        xn.im = sat(q_im >>> FRAC);

        sl_src  = (state == S_SOLVE) ? xn : nxt;
        sl_v[1] = sl_src.re;
        sl_v[0] = sl_src.im;
        sym_n   = mode_q ? {sl_b[1], sl_b[0]} : {2'b00, sl_b[1][1], sl_b[0][1]};
    end

    for (genvar d = 0; d < 2; d++) begin : g_slice
        mimo_backsub_slice #(.W(W), .FRAC(FRAC)) u_slice (
            .v    (sl_v[d]),
            .bits (sl_b[d])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LOAD;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_x_real <= '0;
            out_x_imag <= '0;
            out_sym    <= '0;
            row        <= '0;
            step       <= '0;
            mode_q     <= 1'b0;
            acc_re     <= '0;
            acc_im     <= '0;
            z          <= '0;
            x          <= '0;
            r          <= '0;
            rinv       <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            if (int'(in_addr) == i)     z[i]    <= {in_real, in_imag};
                            if (int'(in_addr) == N + i) rinv[i] <= in_real;
                        end
                        for (int k = 0; k < NR; k++)
                            if (int'(in_addr) == 2 * N + k) r[k] <= {in_real, in_imag};
                        if (in_last) begin
                            mode_q   <= mode;
                            state    <= S_SOLVE;
                            in_ready <= 1'b0;
                            row      <= 2'(N - 1);
                            step     <= '0;
                        end
                    end
                end
                S_SOLVE: begin
                    if (last_step) begin
                        for (int i = 0; i < N; i++)
                            if (int'(row) == i) x[i] <= xn;
                        if (row == 2'd0) begin
                            // x_0 is ready this cycle; present it without a bubble
                            state      <= S_OUT;
                            out_valid  <= 1'b1;
                            out_idx    <= '0;
                            out_x_real <= xn.re;
                            out_x_imag <= xn.im;
                            out_sym    <= sym_n;
                        end else begin
                            row  <= row - 2'd1;
                            step <= '0;
                        end
                    end else begin
                        acc_re <= acc_re_n;
                        acc_im <= acc_im_n;
                        step   <= step + 2'd1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (int'(out_idx) == N - 1) begin
                            state     <= S_LOAD;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            out_idx    <= out_idx + 2'd1;
                            out_x_real <= nxt.re;
                            out_x_imag <= nxt.im;
                            out_sym    <= sym_n;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_mimo_backsub_detector.sv
// Bench for mimo_backsub_detector (N=2): directed vector table, handshake corner
// sequences and randomized frames checked against a back-substitution model.
module tb_mimo_backsub_detector;
    localparam int N = 2, W = 28, FRAC = 8, AW = 4;
    localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (W - 1));
    localparam longint THR  = 2 * (longint'(1) <<< FRAC);
    localparam int LAT = N * (N + 1) / 2 + 1;

    logic clk = 0, rst = 1, mode = 0, in_valid = 0, in_last = 0, out_ready = 1;
    logic in_ready, out_valid;
    logic [AW-1:0] in_addr;
    logic signed [W-1:0] in_real, in_imag, out_x_real, out_x_imag;
    logic [1:0] out_idx;
    logic [3:0] out_sym;

    int compared = 0, mismatched = 0;

    mimo_backsub_detector #(.N(N), .W(W), .FRAC(FRAC), .AW(AW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_x_real(out_x_real), .out_x_imag(out_x_imag), .out_sym(out_sym)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    longint mz_re[N], mz_im[N], mrv[N], mr_re[N][N], mr_im[N][N];
    longint ex_re[N], ex_im[N];
    int     esym[N];
    bit     mmode;

    function automatic longint wrapw(longint v, int b);
        return (v <<< (64 - b)) >>> (64 - b);
    endfunction

    function automatic longint satw(longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic int sl(longint v);
        if (v < -THR) return 0;
        if (v < 0)    return 1;
        if (v < THR)  return 3;
        return 2;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mz_re[i] = 0; mz_im[i] = 0; mrv[i] = 0;
            for (int j = 0; j < N; j++) begin mr_re[i][j] = 0; mr_im[i][j] = 0; end
        end
        mmode = 0;
    endfunction

    function automatic void model_write(int a, longint re, longint im, bit last, bit m);
        int k;
        re = wrapw(re, W);
        im = wrapw(im, W);
        if (a < N) begin
            mz_re[a] = re; mz_im[a] = im;
        end else if (a < 2 * N) begin
            mrv[a - N] = re;
        end else begin
            k = 2 * N;
            for (int i = 0; i < N; i++)
                for (int j = i + 1; j < N; j++) begin
                    if (a == k) begin mr_re[i][j] = re; mr_im[i][j] = im; end
                    k++;
                end
        end
        if (last) mmode = m;
    endfunction

    function automatic void model_compute();
        longint ar, ai, pr, pi;
        for (int i = N - 1; i >= 0; i--) begin
            ar = mz_re[i];
            ai = mz_im[i];
            for (int j = i + 1; j < N; j++) begin
                pr = wrapw((mr_re[i][j] * ex_re[j] - mr_im[i][j] * ex_im[j]) >>> FRAC, W);
                pi = wrapw((mr_re[i][j] * ex_im[j] + mr_im[i][j] * ex_re[j]) >>> FRAC, W);
                ar = wrapw(ar - pr, W + 2);
                ai = wrapw(ai - pi, W + 2);
            end
            ex_re[i] = satw((ar * mrv[i]) >>> FRAC);
            ex_im[i] = satw((ai * mrv[i]) >>> FRAC);
            esym[i]  = mmode ? sl(ex_re[i]) * 4 + sl(ex_im[i])
                             : (ex_re[i] >= 0 ? 2 : 0) + (ex_im[i] >= 0 ? 1 : 0);
        end
    endfunction

    // ---------------- bench helpers ----------------
    longint got_re[N], got_im[N];
    int     got_sym[N];
    int     got_lat;

    task automatic chk(input string nm, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic put(input int a, input longint re, input longint im, input bit last, input bit m);
        @(negedge clk);
        in_valid = 1; in_addr = AW'(a); in_real = W'(re); in_imag = W'(im);
        in_last = last; mode = m;
        model_write(a, re, im, last, m);
        @(posedge clk);
    endtask

    task automatic wait_out(input bit junk);
        int n, cyc;
        n = 0; cyc = 0; got_lat = 0;
        while (n < N && cyc < 50) begin
            @(negedge clk);
            cyc++;
            in_valid = junk; in_last = 0; in_addr = '0;
            if (junk) begin in_real = W'($urandom); in_imag = W'($urandom); end
            if (out_valid) begin
                if (n == 0) got_lat = cyc;
                chk($sformatf("out_idx beat %0d", n), out_idx, n);
                got_re[n] = out_x_real; got_im[n] = out_x_imag; got_sym[n] = out_sym;
                n++;
            end
        end
        if (n < N) chk("result beats before timeout", n, N);
        @(negedge clk);
        in_valid = 0;
        chk("in_ready after frame", in_ready, 1);
        chk("out_valid after frame", out_valid, 0);
    endtask

    task automatic chk_model(input string tag);
        model_compute();
        chk({tag, " latency"}, got_lat, LAT);
        for (int n = 0; n < N; n++) begin
            chk($sformatf("%s x%0d re", tag, n), got_re[n], ex_re[n]);
            chk($sformatf("%s x%0d im", tag, n), got_im[n], ex_im[n]);
            chk($sformatf("%s sym%0d", tag, n), got_sym[n], esym[n]);
        end
    endtask

    function automatic longint rs(int b);
        return longint'($urandom_range(0, (1 << b) - 1)) - (longint'(1) <<< (b - 1));
    endfunction

    function automatic longint rval(int a);
        if ($urandom_range(0, 7) == 0) return wrapw(longint'($urandom), W);
        if (a >= N && a < 2 * N) return longint'($urandom_range(0, 600));
        if (a >= 2 * N) return rs(11);
        return rs(14);
    endfunction

    typedef struct {
        bit     mode;
        longint z0r, z0i, z1r, z1i, rv0, rv1, rr, ri;
        longint x0r, x0i, x1r, x1i;
        int     s0, s1;
    } vec_t;
    vec_t tbl[6];

    task automatic send_tbl(input vec_t v);
        put(0, v.z0r, v.z0i, 0, v.mode);
        put(1, v.z1r, v.z1i, 0, v.mode);
        put(2, v.rv0, rs(10), 0, v.mode);
        put(3, v.rv1, rs(10), 0, v.mode);
        put(4, v.rr, v.ri, 1, v.mode);
    endtask

    initial begin
        int cyc, nw, a;
        bit seen, fm;
        longint re, im;

        tbl[0] = '{0, 256, -256, -256, 256, 256, 256, 0, 0, 256, -256, -256, 256, 2, 1};
        tbl[1] = '{1, 768, 256, 256, 0, 256, 256, 256, 0, 512, 256, 256, 0, 11, 15};
        // -512 sits exactly on -THR and slices to 01
        tbl[2] = '{1, 1024, -1024, 0, 0, 128, 256, 0, 0, 512, -512, 0, 0, 9, 15};
        tbl[3] = '{1, 1 << 26, -(1 << 26), 0, 0, 1 << 20, 0, 0, 0, MAXV, MINV, 0, 0, 8, 15};
        tbl[4] = '{1, -1024, 0, 256, 512, 256, 256, 0, 256, -512, -256, 256, 512, 5, 14};
        tbl[5] = '{0, 1000, -1000, 5, 5, 0, 0, 300, 300, 0, 0, 0, 0, 3, 3};

        in_addr = '0; in_real = '0; in_imag = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_idx", out_idx, 0);
        chk("reset out_x_real", out_x_real, 0);
        chk("reset out_x_imag", out_x_imag, 0);
        chk("reset out_sym", out_sym, 0);
        rst = 0;

        for (int t = 0; t < 6; t++) begin
            send_tbl(tbl[t]);
            wait_out(0);
            chk($sformatf("tbl%0d latency", t), got_lat, LAT);
            chk($sformatf("tbl%0d x0 re", t), got_re[0], tbl[t].x0r);
            chk($sformatf("tbl%0d x0 im", t), got_im[0], tbl[t].x0i);
            chk($sformatf("tbl%0d x1 re", t), got_re[1], tbl[t].x1r);
            chk($sformatf("tbl%0d x1 im", t), got_im[1], tbl[t].x1i);
            chk($sformatf("tbl%0d sym0", t), got_sym[0], tbl[t].s0);
            chk($sformatf("tbl%0d sym1", t), got_sym[1], tbl[t].s1);
        end

        // backpressure: idx0 must hold while out_ready is low
        send_tbl(tbl[1]);
        out_ready = 0;
        cyc = 0;
        do begin
            @(negedge clk); in_valid = 0; in_last = 0; cyc++;
        end while (!out_valid && cyc < 50);
        chk("bp out_valid rises", out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp hold valid", out_valid, 1);
            chk("bp hold idx", out_idx, 0);
            chk("bp hold x re", out_x_real, 512);
            chk("bp hold x im", out_x_imag, 256);
            chk("bp hold sym", out_sym, 11);
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp release valid", out_valid, 1);
        chk("bp release idx", out_idx, 1);
        chk("bp release x re", out_x_real, 256);
        chk("bp release sym", out_sym, 15);
        @(negedge clk);
        chk("bp done in_ready", in_ready, 1);
        chk("bp done out_valid", out_valid, 0);

        // in_last on an unmapped address, with junk load words during SOLVE/OUT
        put(0, rs(14), rs(14), 0, 1);
        put(1, rs(14), rs(14), 0, 1);
        put(2, 200, 0, 0, 1);
        put(3, 300, 0, 0, 1);
        put(4, rs(11), rs(11), 0, 1);
        put(9, rs(14), rs(14), 1, 1);
        wait_out(1);
        chk_model("unmapped last");
        // only R01 reloaded: other registers must have survived the junk
        put(4, rs(11), rs(11), 1, 0);
        wait_out(0);
        chk_model("persist");

        // reset on the second SOLVE cycle aborts the frame
        send_tbl(tbl[1]);
        @(negedge clk); in_valid = 0; in_last = 0;
        @(negedge clk); rst = 1;
        #1;
        chk("abort in_ready", in_ready, 1);
        chk("abort out_valid", out_valid, 0);
        model_reset();
        @(negedge clk); rst = 0;
        seen = 0;
        repeat (10) begin @(negedge clk); if (out_valid) seen = 1; end
        chk("abort no beat", seen, 0);
        put(0, 256, 256, 0, 0);
        put(2, 256, 0, 1, 0);
        wait_out(0);
        chk("post-abort latency", got_lat, LAT);
        chk("post-abort x0 re", got_re[0], 256);
        chk("post-abort x0 im", got_im[0], 256);
        chk("post-abort sym0", got_sym[0], 3);
        chk("post-abort x1 re", got_re[1], 0);
        chk("post-abort x1 im", got_im[1], 0);
        chk("post-abort sym1", got_sym[1], 3);

        // randomized frames: partial loads, unmapped addresses, mode on last beat only
        for (int f = 0; f < 40; f++) begin
            nw = $urandom_range(1, 6);
            fm = 1'($urandom_range(0, 1));
            for (int w = 0; w < nw; w++) begin
                a  = $urandom_range(0, 7);
                re = rval(a);
                im = rval(a);
                put(a, re, im, w == nw - 1, (w == nw - 1) ? fm : 1'($urandom_range(0, 1)));
            end
            wait_out(f % 5 == 0);
            chk_model($sformatf("rnd%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
